// File: rtl/cache_tq_alloc_if.sv
// Transaction-queue allocator bundle: alloc request/response, free, CAM lookup, status.
// master drives requests (core side); slave is the allocator.
interface cache_tq_alloc_if #(
    parameter int ID_WIDTH      = 3,
    parameter int CL_ADRS_WIDTH = 16
);
    logic                     AllocReq;
    logic [CL_ADRS_WIDTH-1:0] AllocClAddr;
    logic                     AllocAck;
    logic [ID_WIDTH-1:0]      AllocId;
    logic                     AllocReject;
    logic                     RejectFull;
    logic                     RejectHazard;
    logic                     FreeReq;
    logic [ID_WIDTH-1:0]      FreeId;
    logic [CL_ADRS_WIDTH-1:0] LookupClAddr;
    logic                     LookupHit;
    logic [ID_WIDTH-1:0]      LookupId;
    logic [ID_WIDTH:0]        Count;
    logic                     Full;
    logic                     Empty;
    logic                     FreeErr;

    modport master (
        output AllocReq, AllocClAddr, FreeReq, FreeId, LookupClAddr,
        input  AllocAck, AllocId, AllocReject, RejectFull, RejectHazard,
        input  LookupHit, LookupId, Count, Full, Empty, FreeErr
    );

    modport slave (
        input  AllocReq, AllocClAddr, FreeReq, FreeId, LookupClAddr,
        output AllocAck, AllocId, AllocReject, RejectFull, RejectHazard,
        output LookupHit, LookupId, Count, Full, Empty, FreeErr
    );
endinterface

// File: rtl/cache_tq_alloc.sv
// TQ entry allocator/tracker: grants IDs, rejects line hazards and full, frees, CAM lookup.
// Ports: Clk, RstN (sync active-low), tq (slave modport). Macro CACHE_TQ_RR_ALLOC_EN enables round-robin selection.
module cache_tq_alloc #(
    parameter int ID_WIDTH      = 3,
    parameter int CL_ADRS_WIDTH = 16,
    parameter int NUM_ENTRY     = 2**ID_WIDTH
) (
    input  logic             Clk,
    input  logic             RstN,
    cache_tq_alloc_if.slave  tq
);
    localparam logic [ID_WIDTH:0] FULL_CNT = (ID_WIDTH+1)'(NUM_ENTRY);

    logic [NUM_ENTRY-1:0]     valid_q;
    logic [CL_ADRS_WIDTH-1:0] addr_q [NUM_ENTRY];
    logic [ID_WIDTH:0]        count_q;
    logic                     ack_q;
    logic [ID_WIDTH-1:0]      id_q;
    logic                     rej_q;
    logic                     rf_q;
    logic                     rh_q;
    logic                     ferr_q;

    logic                     hazard;
    logic                     full;
    logic [ID_WIDTH-1:0]      sel;
    logic                     sel_ok;
    logic                     grant;
    logic                     free_ok;
    logic                     free_bad;
    logic                     hit;
    logic [ID_WIDTH-1:0]      hit_id;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (valid_q[i] && addr_q[i] == tq.AllocClAddr) hazard = 1'b1;
        end
    end

    assign full = (count_q == FULL_CNT);

`ifdef CACHE_TQ_RR_ALLOC_EN
    logic [ID_WIDTH-1:0] rr_q;
    logic [ID_WIDTH-1:0] idx;

    // Scan from the pointer; ID_WIDTH-bit addition wraps modulo NUM_ENTRY.
    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            idx = rr_q + ID_WIDTH'(i);
            if (!sel_ok && !valid_q[idx]) begin
                sel    = idx;
                sel_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!RstN) rr_q <= '0;
        else if (grant) rr_q <= sel + 1'b1;
    end
`else
    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (!sel_ok && !valid_q[i]) begin
                sel    = ID_WIDTH'(i);
                sel_ok = 1'b1;
            end
        end
    end
`endif

    // Selection reads pre-free valid bits, so a slot freed this cycle is never picked.
    assign grant    = tq.AllocReq && !hazard && !full && sel_ok;
    assign free_ok  = tq.FreeReq && valid_q[tq.FreeId];
    assign free_bad = tq.FreeReq && !valid_q[tq.FreeId];

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTRY; i++) addr_q[i] <= '0;
            count_q <= '0;
            ack_q   <= 1'b0;
            id_q    <= '0;
            rej_q   <= 1'b0;
            rf_q    <= 1'b0;
            rh_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            ack_q <= grant;
            id_q  <= grant ? sel : '0;
            rej_q <= tq.AllocReq && !grant;
            rh_q  <= tq.AllocReq && hazard;
            rf_q  <= tq.AllocReq && !hazard && !grant;
            if (free_ok) valid_q[tq.FreeId] <= 1'b0;
            if (grant) begin
                valid_q[sel] <= 1'b1;
                addr_q[sel]  <= tq.AllocClAddr;
            end
            if (free_bad) ferr_q <= 1'b1;
            count_q <= count_q + {{ID_WIDTH{1'b0}}, grant}
                               - {{ID_WIDTH{1'b0}}, free_ok};
        end
    end

    // Lowest matching valid index wins.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (!hit && valid_q[i] && addr_q[i] == tq.LookupClAddr) begin
                hit    = 1'b1;
                hit_id = ID_WIDTH'(i);
            end
        end
    end

    assign tq.AllocAck     = ack_q;
    assign tq.AllocId      = id_q;
    assign tq.AllocReject  = rej_q;
    assign tq.RejectFull   = rf_q;
    assign tq.RejectHazard = rh_q;
    assign tq.LookupHit    = hit;
    assign tq.LookupId     = hit_id;
    assign tq.Count        = count_q;
    assign tq.Full         = full;
    assign tq.Empty        = (count_q == '0);
    assign tq.FreeErr      = ferr_q;
endmodule

// File: tb/tb_cache_tq_alloc.sv
// Self-checking bench for cache_tq_alloc: directed plan plus randomized traffic vs a queue model.
// Default parameters (8 entries, 16-bit line address).
module tb_cache_tq_alloc;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    cache_tq_alloc_if #(.ID_WIDTH(3), .CL_ADRS_WIDTH(16)) tqi ();

    cache_tq_alloc #(.ID_WIDTH(3), .CL_ADRS_WIDTH(16)) dut (
        .Clk  (clk),
        .RstN (rstn),
        .tq   (tqi.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Model state
    bit          m_v [8];
    logic [15:0] m_a [8];
    int          m_cnt;
    bit          m_ferr;
    int          m_ptr;
    bit          e_ack, e_rej, e_rf, e_rh;
    int          e_id;

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void model(bit rst, bit req, logic [15:0] a, bit fr, int fid);
        bit hz;
        int pick;
        if (rst) begin
            foreach (m_v[i]) begin m_v[i] = 0; m_a[i] = '0; end
            m_cnt = 0; m_ferr = 0; m_ptr = 0;
            e_ack = 0; e_rej = 0; e_rf = 0; e_rh = 0; e_id = 0;
            return;
        end
        hz = 0;
        foreach (m_v[i]) if (m_v[i] && m_a[i] == a) hz = 1;
        e_ack = 0; e_rej = 0; e_rf = 0; e_rh = 0; e_id = 0;
        pick = -1;
        if (req) begin
            if (hz) begin e_rej = 1; e_rh = 1; end
            else if (m_cnt == 8) begin e_rej = 1; e_rf = 1; end
            else begin
                for (int k = 0; k < 8; k++)
                    if (pick < 0 && !m_v[(m_ptr + k) % 8]) pick = (m_ptr + k) % 8;
                e_ack = 1; e_id = pick;
            end
        end
        if (fr) begin
            if (m_v[fid]) begin m_v[fid] = 0; m_cnt--; end
            else m_ferr = 1;
        end
        if (pick >= 0) begin
            m_v[pick] = 1; m_a[pick] = a; m_cnt++;
`ifdef CACHE_TQ_RR_ALLOC_EN
            m_ptr = (pick + 1) % 8;
`endif
        end
    endfunction

    task automatic cyc(bit rst, bit req, logic [15:0] a, bit fr, int fid, logic [15:0] lk);
        #1;
        rstn             = !rst;
        tqi.AllocReq     = req;
        tqi.AllocClAddr  = a;
        tqi.FreeReq      = fr;
        tqi.FreeId       = 3'(fid);
        tqi.LookupClAddr = lk;
        @(posedge clk);
        model(rst, req, a, fr, fid);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            bit lh;
            int li;
            lh = 0; li = 0;
            for (int i = 7; i >= 0; i--)
                if (m_v[i] && m_a[i] == tqi.LookupClAddr) begin lh = 1; li = i; end
            chk("ack", int'(tqi.AllocAck), int'(e_ack));
            if (e_ack) chk("id", int'(tqi.AllocId), e_id);
            chk("reject", int'(tqi.AllocReject), int'(e_rej));
            chk("rej_full", int'(tqi.RejectFull), int'(e_rf));
            chk("rej_hazard", int'(tqi.RejectHazard), int'(e_rh));
            chk("count", int'(tqi.Count), m_cnt);
            chk("full", int'(tqi.Full), int'(m_cnt == 8));
            chk("empty", int'(tqi.Empty), int'(m_cnt == 0));
            chk("free_err", int'(tqi.FreeErr), int'(m_ferr));
            chk("lookup_hit", int'(tqi.LookupHit), int'(lh));
            chk("lookup_id", int'(tqi.LookupId), li);
        end
    end

    initial begin
        rstn = 1'b0;
        tqi.AllocReq = 0; tqi.AllocClAddr = '0; tqi.FreeReq = 0;
        tqi.FreeId = '0; tqi.LookupClAddr = '0;
        model(1, 0, '0, 0, 0);

        cyc(1, 0, 16'h0, 0, 0, 16'h0);
        chk_on = 1'b1;
        cyc(1, 0, 16'h0, 0, 0, 16'h0);
        chk("rst_count", int'(tqi.Count), 0);
        chk("rst_empty", int'(tqi.Empty), 1);

        // Fill all eight entries
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 16'h0010 + 16'(i), 0, 0, 16'h0);
            chk("fill_ack", int'(tqi.AllocAck), 1);
            chk("fill_id", int'(tqi.AllocId), i);
        end
        chk("fill_count", int'(tqi.Count), 8);
        chk("fill_full", int'(tqi.Full), 1);
        cyc(0, 1, 16'h0020, 0, 0, 16'h0);
        chk("ninth_rej", int'(tqi.AllocReject), 1);
        chk("ninth_rf", int'(tqi.RejectFull), 1);

        // Hazard on line 0x0012 (entry 2)
        cyc(0, 1, 16'h0012, 0, 0, 16'h0012);
        chk("hz_rej", int'(tqi.AllocReject), 1);
        chk("hz_rh", int'(tqi.RejectHazard), 1);
        chk("hz_rf", int'(tqi.RejectFull), 0);
        chk("hz_count", int'(tqi.Count), 8);
        chk("lk_hit", int'(tqi.LookupHit), 1);
        chk("lk_id", int'(tqi.LookupId), 2);

        // Free while full plus alloc: still rejected, then slot 5 reused
        cyc(0, 1, 16'h0030, 1, 5, 16'h0);
        chk("ff_rej", int'(tqi.AllocReject), 1);
        chk("ff_rf", int'(tqi.RejectFull), 1);
        chk("ff_count", int'(tqi.Count), 7);
        cyc(0, 1, 16'h0030, 0, 0, 16'h0);
        chk("reuse_ack", int'(tqi.AllocAck), 1);
        chk("reuse_id", int'(tqi.AllocId), 5);
        chk("reuse_count", int'(tqi.Count), 8);

        // Double free of entry 3
        cyc(0, 0, 16'h0, 1, 3, 16'h0);
        chk("free1_count", int'(tqi.Count), 7);
        chk("free1_err", int'(tqi.FreeErr), 0);
        cyc(0, 0, 16'h0, 1, 3, 16'h0);
        chk("free2_count", int'(tqi.Count), 7);
        chk("free2_err", int'(tqi.FreeErr), 1);
        cyc(0, 0, 16'h0, 0, 0, 16'h0);
        chk("err_sticky", int'(tqi.FreeErr), 1);
        chk("idle_ack", int'(tqi.AllocAck), 0);

        // Selection policy after a free
        cyc(1, 0, 16'h0, 0, 0, 16'h0);
        chk("rst_err", int'(tqi.FreeErr), 0);
        cyc(0, 1, 16'h0040, 0, 0, 16'h0);
        cyc(0, 1, 16'h0041, 0, 0, 16'h0);
        cyc(0, 0, 16'h0, 1, 0, 16'h0);
        cyc(0, 1, 16'h0042, 0, 0, 16'h0);
`ifdef CACHE_TQ_RR_ALLOC_EN
        chk("policy_id", int'(tqi.AllocId), 2);
`else
        chk("policy_id", int'(tqi.AllocId), 0);
`endif

        // Reset with a pending request and four valid entries
        cyc(0, 1, 16'h0043, 0, 0, 16'h0);
        cyc(0, 1, 16'h0044, 0, 0, 16'h0);
        chk("four_count", int'(tqi.Count), 4);
        cyc(1, 1, 16'h0045, 0, 0, 16'h0);
        chk("mid_rst_ack", int'(tqi.AllocAck), 0);
        chk("mid_rst_count", int'(tqi.Count), 0);
        chk("mid_rst_empty", int'(tqi.Empty), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 16'h0, 0, 0, 16'h0041 + 16'(i));
            chk("mid_rst_lk", int'(tqi.LookupHit), 0);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit r, q, f;
            q = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 299) == 0);
            f = ($urandom_range(0, 9) < 4);
            cyc(r, q, 16'h0100 + 16'($urandom_range(0, 11)), f,
                int'($urandom_range(0, 7)), 16'h0100 + 16'($urandom_range(0, 11)));
        end

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_tq_alloc.md
Name: cache_tq_alloc

Overview:
- Parametrised transaction-queue entry allocator and tracker for the cache pipeline; it generalises the fixed 8-entry TQ to any 2**ID_WIDTH depth and any cache-line address width.
- Hands out TQ IDs to incoming core requests and holds a per-entry valid bit and cache-line address.
- Rejects same-line hazards and requests that arrive when full. Frees entries on completion.
- Provides a CAM lookup for fill/response routing.

Parameters:
- ID_WIDTH, 3, TQ ID width.
- NUM_ENTRY, 2**ID_WIDTH, entry count (derived; do not override).
- CL_ADRS_WIDTH, 16, cache-line address width (tag+set).

Ports:
- Clk  in  1  clock
- RstN  in  1  synchronous active-low reset
- AllocReq  in  1  allocate request, single-cycle pulse per request
- AllocClAddr  in  CL_ADRS_WIDTH  line address of request
- AllocAck  out  1  registered: allocation granted
- AllocId  out  ID_WIDTH  registered: granted ID (valid with AllocAck)
- AllocReject  out  1  registered: request rejected
- RejectFull  out  1  registered: reject cause = full
- RejectHazard  out  1  registered: reject cause = line match
- FreeReq  in  1  free request
- FreeId  in  ID_WIDTH  entry to free
- LookupClAddr  in  CL_ADRS_WIDTH  CAM key
- LookupHit  out  1  combinational: a valid entry matches
- LookupId  out  ID_WIDTH  combinational: lowest matching index
- Count  out  ID_WIDTH+1  registered: number of valid entries
- Full  out  1  Count==NUM_ENTRY
- Empty  out  1  Count==0
- FreeErr  out  1  sticky: a free targeted an already-free entry

Behaviour:
- Reset: synchronous when RstN==0 at a rising edge of Clk. Clears all valid bits and addresses. AllocAck, AllocId, AllocReject, RejectFull, RejectHazard, FreeErr = 0; Count = 0; Empty = 1; Full = 0. Reset mid-operation discards all entries; no pending ack is issued.
- Allocation latency is 1 cycle. AllocReq at cycle N produces exactly one of AllocAck or AllocReject during cycle N+1, each a 1-cycle pulse. Both are 0 in any cycle that follows a cycle with no AllocReq.
- Accepting AllocReq, evaluated on state before the edge:
  - Hazard: any valid entry whose address == AllocClAddr → reject, RejectHazard=1.
  - Else full → reject, RejectFull=1.
  - Hazard has priority over full; both cause bits are never set together.
  - Otherwise the selected free index becomes valid with AllocClAddr, and AllocId = that index.
- Selection: lowest-index free entry (see optional feature).
- Free: FreeReq with FreeId valid → entry invalid at the next edge.
  - FreeId already invalid → no state change, FreeErr set; it stays set until reset.
- Simultaneous alloc and free in the same cycle:
  - Full/hazard checks use pre-free state; there is no bypass. Alloc while full plus a free in the same cycle is rejected.
  - The freed slot is not reusable until the following cycle. Allocation never selects FreeId in that cycle.
  - Count: +1 on grant, -1 on valid free, net 0 when both occur.
- Lookup: pure CAM over valid entries only, zero latency. LookupId = 0 when LookupHit = 0.
- Count never exceeds NUM_ENTRY and never underflows; erroneous frees do not decrement it.
- Full and Empty are decoded from the registered Count.

Optional Feature:
- Macro CACHE_TQ_RR_ALLOC_EN.
- Defined: a round-robin pointer (ID_WIDTH bits, reset 0) is kept. Allocation picks the first free index at or after the pointer, wrapping modulo NUM_ENTRY. On each grant the pointer becomes AllocId+1, wrapping to 0.
- Undefined: fixed lowest-index-first selection with no pointer register.
- Hazard, full, free and lookup behaviour are identical in both builds.

Test Plan:
- Reset, then 8 allocs with ID_WIDTH=3 and addresses 0x0010..0x0017 → AllocId 0..7 each one cycle later; Count=8, Full=1. A 9th alloc at 0x0020 → AllocReject=1, RejectFull=1.
- With entry 2 = 0x0012, alloc 0x0012 → AllocReject=1, RejectHazard=1, Count unchanged. LookupClAddr=0x0012 → LookupHit=1, LookupId=2.
- Full queue; FreeReq(5) together with alloc 0x0030 → rejected (full). Next cycle alloc 0x0030 → AllocId=5; Count stays 8.
- Free ID 3 twice → first free sets Count 8→7; second free sets FreeErr=1 and leaves Count=7. FreeErr holds until RstN low.
- Alloc IDs 0,1; free 0; alloc again → lowest-first build gives AllocId=0; with CACHE_TQ_RR_ALLOC_EN the build gives AllocId=2.
- 4 entries valid; drive RstN low for 1 cycle together with an AllocReq → next cycle AllocAck=0, Count=0, Empty=1, LookupHit=0 for all prior addresses.
